lfsr_prbs_gen: RTL
==================

// Module: lfsr_prbs_gen
// PURPOSE
//  Parametrised Fibonacci LFSR / PRBS source for scramblers, BIST and test-pattern links.
//  - Emits NB sequence bits per transfer over a valid/ready stream.
//  - Supports runtime seed reload, recovers from the all-zero lockup state, and flags each
//    completed sequence period.
// PARAMETERS
//  WIDTH     8          LFSR length, legal 3..32; tap mask taken from lfsr_pkg::TAP_MASK(WIDTH)
//  NB        1          bits produced per transfer, legal 1..WIDTH
//  SEED      all ones   reset / fallback seed, WIDTH bits, must be non-zero
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous reset, active-low
//  en           in   1      generator enable; 0 freezes state and drops out_valid
//  load_en      in   1      load load_seed this cycle
//  load_seed    in   WIDTH  new seed value
//  out_data     out  NB     sequence bits; bit 0 is the earliest serial bit
//  out_valid    out  1      out_data valid
//  out_ready    in   1      consumer accepts out_data
//  lfsr_state   out  WIDTH  current register contents s
//  period_wrap  out  1      1-cycle pulse: full period of 2^WIDTH-1 bits completed
//  lockup_fix   out  1      1-cycle pulse: all-zero seed replaced by SEED
// BEHAVIOUR
//  - Single step: fb = ^(s & TAP_MASK); s_next = {fb, s[WIDTH-1:1]}; serial bit = s[0].
//  - out_data[i] = serial bit i of NB chained single steps from the current s (combinational
//    from s). On transfer (out_valid & out_ready), s advances by NB steps.
//  - Reset values: s = SEED, out_valid = 0, period_wrap = 0, lockup_fix = 0, bit counter = 0.
//  - FSM, 2 states:
//    - INIT: entered at reset or after a load; out_valid = 0.
//    - RUN: out_valid = en.
//    - INIT -> RUN on the next clk edge with en = 1; stays in INIT while en = 0.
//    - First valid data appears 1 cycle after reset release.
//  - Load: load_en = 1 has priority over a transfer in the same cycle.
//    - The transfer is discarded and s is not advanced from its old value.
//    - s <= load_seed, or SEED if load_seed == 0 (lockup_fix pulses the next cycle).
//    - FSM -> INIT; bit counter cleared.
//    - load_en is accepted regardless of en.
//  - Lockup: the all-zero state is unreachable except through load; that path is always fixed.
//  - Backpressure: while out_valid & !out_ready, out_data and s hold stable.
//    - en = 0 also freezes s.
//  - Bit counter: WIDTH+1 bits; on each transfer it adds NB modulo (2^WIDTH-1).
//    - period_wrap pulses the cycle after any transfer whose addition wraps.
//    - With NB = 1, the pulse is coincident with s returning to its loaded value.
//  - Reset mid-operation: immediate return to reset values, no partial step retained.
// CONFIGURATION
//  LFSR_ERR_INJ_EN defined:
//    - adds input err_inj (1 bit).
//    - A pulse arms a flag; the next accepted transfer has out_data[0] inverted and clears the flag.
//    - s is never corrupted.
//    - The flag resets to 0 and is cleared by load.
//  Not defined: port absent; out_data is always the pure sequence.
// STRUCTURE
//  lfsr_pkg:
//    - function TAP_MASK(w): maximal-length mask table for w = 3..32 (w = 8 -> 8'h71, bits 0,4,5,6).
//    - Constant table of periods 2^w-1.
//    - Parameter-legality checks.
//  Sub-module lfsr_step: combinational one-step next-state and serial bit; chained NB times by generate.
// TESTING
//  - WIDTH=8, NB=1, SEED=8'hFF, out_ready=1:
//    - after reset, states FF,7F,3F,9F on successive transfers, out_data=1 each time.
//    - period_wrap after transfer 255 with s == 8'hFF.
//  - Same bench, out_ready low for 5 cycles mid-run: out_data and lfsr_state constant, no advance.
//    - Resume matches the golden stream bit-for-bit.
//  - NB=8:
//    - first out_data = 8'hFF.
//    - each word equals 8 consecutive bits of the NB=1 model, bit 0 first.
//    - period_wrap at the word where 8*k crosses a multiple of 255.
//  - load_en with load_seed=0 during a pending transfer:
//    - transfer dropped; s = 8'hFF; lockup_fix one pulse; out_valid low one cycle.
//  - load_seed=8'h5A: stream restarts from 5A, bit counter cleared.
//  - Assert rst_n low mid-stream for 1 cycle: all outputs at reset values, first valid data again FF.
//  - LFSR_ERR_INJ_EN: err_inj pulse -> only the next accepted out_data[0] inverted; later bits match the model.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length tap masks, period table, generator FSM states and
// parameter-legality checks shared by the LFSR/PRBS generator.
package lfsr_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_e;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 32;

  // Mask bit k set means s[k] feeds the XOR, i.e. polynomial x^w + sum(x^k).
  function automatic logic [31:0] TAP_MASK(input int w);
    logic [31:0] m;
    case (w)
      3:       m = 32'h0000_0005;
      4:       m = 32'h0000_0009;
      5:       m = 32'h0000_0009;
      6:       m = 32'h0000_0021;
      7:       m = 32'h0000_0041;
      8:       m = 32'h0000_0071;
      9:       m = 32'h0000_0021;
      10:      m = 32'h0000_0081;
      11:      m = 32'h0000_0201;
      12:      m = 32'h0000_0053;
      13:      m = 32'h0000_001B;
      14:      m = 32'h0000_002B;
      15:      m = 32'h0000_4001;
      16:      m = 32'h0000_A011;
      17:      m = 32'h0000_4001;
      18:      m = 32'h0000_0801;
      19:      m = 32'h0000_0047;
      20:      m = 32'h0002_0001;
      21:      m = 32'h0008_0001;
      22:      m = 32'h0020_0001;
      23:      m = 32'h0004_0001;
      24:      m = 32'h00C2_0001;
      25:      m = 32'h0040_0001;
      26:      m = 32'h0000_0047;
      27:      m = 32'h0000_0027;
      28:      m = 32'h0200_0001;
      29:      m = 32'h0800_0001;
      30:      m = 32'h0000_0053;
      31:      m = 32'h1000_0001;
      32:      m = 32'h0040_0007;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  typedef logic [MAX_WIDTH:MIN_WIDTH][32:0] period_table_t;

  function automatic period_table_t build_periods();
    period_table_t t;
    for (int w = MIN_WIDTH; w <= MAX_WIDTH; w++) begin
      t[w] = (33'd1 << w) - 33'd1;
    end
    return t;
  endfunction

  localparam period_table_t PERIOD_TABLE = build_periods();

  function automatic bit params_legal(input int w, input int nb, input bit seed_nonzero);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && (nb >= 1) && (nb <= w) && seed_nonzero;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Fibonacci step; serial bit is the outgoing s[0].
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h71
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_next,
  output logic             serial_bit
);

  logic fb;

  assign fb         = ^(s & TAPS);
  assign s_next     = {fb, s[WIDTH-1:1]};
  assign serial_bit = s[0];

endmodule

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: Fibonacci LFSR / PRBS source emitting NB bits per valid/ready transfer.
// Optional error injection on out_data[0] is enabled by defining LFSR_ERR_INJ_EN.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               NB    = 1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_seed,
`ifdef LFSR_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic [NB-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             period_wrap,
  output logic             lockup_fix
);

  localparam logic [31:0]      TAPS_FULL   = TAP_MASK(WIDTH);
  localparam logic [WIDTH-1:0] TAPS        = TAPS_FULL[WIDTH-1:0];
  localparam logic [32:0]      PERIOD_FULL = PERIOD_TABLE[WIDTH];
  localparam logic [WIDTH:0]   PERIOD      = PERIOD_FULL[WIDTH:0];
  localparam logic [WIDTH:0]   NB_INC      = (WIDTH+1)'(NB);

  if (!params_legal(WIDTH, NB, SEED != '0)) begin : g_bad_params
    $error("lfsr_prbs_gen: illegal WIDTH/NB/SEED combination");
  end

  gen_state_e       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH:0]   cnt_q, cnt_d, cnt_sum;
  logic             period_wrap_q, period_wrap_d;
  logic             lockup_fix_q, lockup_fix_d;
  logic             xfer;
  logic [NB-1:0]    seq_bits;
  logic [WIDTH-1:0] chain [0:NB];

  assign chain[0] = lfsr_q;

  for (genvar i = 0; i < NB; i++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .s          (chain[i]),
      .s_next     (chain[i+1]),
      .serial_bit (seq_bits[i])
    );
  end

  assign out_valid = (state_q == ST_RUN) && en;
  // A load in the same cycle discards the handshake entirely.
  assign xfer      = out_valid && out_ready && !load_en;
  assign cnt_sum   = cnt_q + NB_INC;

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    cnt_d         = cnt_q;
    period_wrap_d = 1'b0;
    lockup_fix_d  = 1'b0;
    if (load_en) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      if (load_seed == '0) begin
        lfsr_d       = SEED;
        lockup_fix_d = 1'b1;
      end else begin
        lfsr_d = load_seed;
      end
    end else begin
      if ((state_q == ST_INIT) && en) begin
        state_d = ST_RUN;
      end
      if (xfer) begin
        lfsr_d = chain[NB];
        if (cnt_sum >= PERIOD) begin
          cnt_d         = cnt_sum - PERIOD;
          period_wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      lfsr_q        <= SEED;
      cnt_q         <= '0;
      period_wrap_q <= 1'b0;
      lockup_fix_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cnt_q         <= cnt_d;
      period_wrap_q <= period_wrap_d;
      lockup_fix_q  <= lockup_fix_d;
    end
  end

`ifdef LFSR_ERR_INJ_EN
  logic err_armed_q, err_armed_d;

  // The armed flag corrupts only the presented word; the register stream is untouched.
  always_comb begin
    err_armed_d = err_armed_q;
    if (load_en) begin
      err_armed_d = 1'b0;
    end else begin
      if (xfer) begin
        err_armed_d = 1'b0;
      end
      if (err_inj) begin
        err_armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_armed_q <= 1'b0;
    end else begin
      err_armed_q <= err_armed_d;
    end
  end

  assign out_data = seq_bits ^ NB'(err_armed_q);
`else
  assign out_data = seq_bits;
`endif

  assign lfsr_state  = lfsr_q;
  assign period_wrap = period_wrap_q;
  assign lockup_fix  = lockup_fix_q;

endmodule
